// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences the shared ALU,
// register file, memory port and PC over 3-5 cycles per instruction.
module multicycle_ctrl #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int RETIRE_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          op,
  input  logic [2:0]          f3,
  input  logic                brTaken,
  input  logic                memReady,
  output logic                pcWrite,
  output logic                adrSrc,
  output logic                irWrite,
  output logic                memWrite,
  output logic                regWrite,
  output logic [1:0]          resultSrc,
  output logic [1:0]          aluSrcA,
  output logic [1:0]          aluSrcB,
  output logic [1:0]          aluOp,
  output logic [1:0]          immSrc,
  output logic                illegalOp,
  output logic                instrDone,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t              r_state;
  state_t              w_next;
  logic [RETIRE_W-1:0] r_retired;

  logic       w_mem_rdy;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_adr_src;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_imm_src;
  logic       w_illegal;
  logic       w_done;
  logic       w_unused;

  // brTaken already reflects the f3-selected condition, so f3 is not decoded here.
  assign w_unused  = ^f3;
  assign w_mem_rdy = MEM_WAIT_EN ? memReady : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state   <= w_next;
      r_retired <= r_retired + RETIRE_W'(w_done);
    end
  end

  always_comb begin
    w_next       = S_FETCH;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_illegal    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = w_mem_rdy;
        w_pc_update  = w_mem_rdy;
        w_next       = w_mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          default: begin
            w_illegal = 1'b1;
            w_done    = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_next      = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        w_next    = w_mem_rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
      end
      S_MEMWRITE: begin
        // The write strobe stays up for the whole wait; completion retires the store.
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_done      = w_mem_rdy;
        w_next      = w_mem_rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_branch    = 1'b1;
        w_done      = 1'b1;
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_JAL:    w_imm_src = 2'b11;
      OP_BRANCH: w_imm_src = 2'b10;
      OP_STORE:  w_imm_src = 2'b01;
      default:   w_imm_src = 2'b00;
    endcase
  end

  // Reset masks every output combinationally, including the debug state.
  assign pcWrite   = ~rst & (w_pc_update | (w_branch & brTaken));
  assign adrSrc    = ~rst & w_adr_src;
  assign irWrite   = ~rst & w_ir_write;
  assign memWrite  = ~rst & w_mem_write;
  assign regWrite  = ~rst & w_reg_write;
  assign resultSrc = rst ? 2'b00 : w_result_src;
  assign aluSrcA   = rst ? 2'b00 : w_alu_src_a;
  assign aluSrcB   = rst ? 2'b00 : w_alu_src_b;
  assign aluOp     = rst ? 2'b00 : w_alu_op;
  assign immSrc    = rst ? 2'b00 : w_imm_src;
  assign illegalOp = ~rst & w_illegal;
  assign instrDone = ~rst & w_done;
  assign retired   = rst ? '0 : r_retired;
  assign state     = rst ? 4'd0 : r_state;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences the shared ALU, register file, instruction/data memory port and PC register over 3–5 cycles per instruction.
- Emits the 2-bit aluOp consumed by the ALU decoder, which turns aluOp, f3, f7 and op into aluControl.
- Sits in the control unit next to the ALU decoder; holds on memory wait states.

Parameters:
- MEM_WAIT_EN, 1: 1 = memory states wait for memReady; 0 = memReady ignored (treated as 1).
- RETIRE_W, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  synchronous, active-high reset
- op  input  7  instr[6:0] from the instruction register
- f3  input  3  instr[14:12]
- brTaken  input  1  ALU compare flag: 1 = branch condition selected by f3 is true
- memReady  input  1  memory port completed the current access this cycle
- pcWrite  output  1  PC register enable
- adrSrc  output  1  0 = PC, 1 = result bus to the memory address
- irWrite  output  1  instruction register enable
- memWrite  output  1  data memory write strobe
- regWrite  output  1  register file write enable
- resultSrc  output  2  00 aluOut reg, 01 read data, 10 ALU result
- aluSrcA  output  2  00 PC, 01 oldPC, 10 rs1 data
- aluSrcB  output  2  00 rs2 data, 01 immediate, 10 constant 4
- aluOp  output  2  00 add, 01 branch compare, 10 decode by f3/f7
- immSrc  output  2  00 I, 01 S, 10 B, 11 J
- illegalOp  output  1  one-cycle pulse on an unsupported opcode
- instrDone  output  1  one-cycle pulse in the final state of each instruction
- retired  output  RETIRE_W  count of instrDone pulses
- state  output  4  current state code, for debug

Behaviour:
- Reset: rst=1 at a clk edge sets state to FETCH and retired to 0. While rst=1, all outputs are forced to 0.
- Outputs are Moore decodes of state, except:
  - FETCH strobes are gated by memReady.
  - pcWrite = pcUpdate | (branch & brTaken).
  - immSrc is decoded from op.
- Any output not listed for a state is 0.
- State codes:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10
- FETCH:
  - adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10.
  - irWrite and pcUpdate assert only when memReady=1.
  - memReady=1 → DECODE; otherwise stay in FETCH.
- DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (branch/jump target). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - any other op → FETCH, with illegalOp=1 and instrDone=1 this cycle
- MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00. op=0000011 → MEMREAD, else → MEMWRITE.
- MEMREAD: adrSrc=1, resultSrc=00. memReady=1 → MEMWB; else hold.
- MEMWB: resultSrc=01, regWrite=1, instrDone=1 → FETCH.
- MEMWRITE:
  - adrSrc=1, resultSrc=00.
  - memWrite held at 1 every cycle until memReady=1.
  - On that cycle instrDone=1 → FETCH.
- EXECR: aluSrcA=10, aluSrcB=00, aluOp=10 → ALUWB.
- EXECI: aluSrcA=10, aluSrcB=01, aluOp=10 → ALUWB.
- ALUWB: resultSrc=00, regWrite=1, instrDone=1 → FETCH.
- BRANCH: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1, instrDone=1 → FETCH.
- JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcUpdate=1 → ALUWB.
- immSrc by op:
  - 11 for 1101111
  - 10 for 1100011
  - 01 for 0100011
  - 00 otherwise
- Latency with memReady always 1:
  - lw = 5 cycles
  - sw, R-type, I-type, jal = 4 cycles
  - branch = 3 cycles
  - illegal = 2 cycles
- retired increments by 1 on each instrDone cycle and wraps modulo 2^RETIRE_W.
- rst asserted in any state, including mid-wait in MEMREAD/MEMWRITE: the next edge goes to FETCH with no further strobes.
- Unused state codes 11–15 → FETCH on the next edge, with no strobes.

Test Plan:
- Reset: rst=1 for 2 cycles, then release with memReady=1 → state=0, all strobes 0 during reset; first cycle after release has irWrite=1, pcWrite=1.
- R-type flow: op=0110011, memReady=1.
  - State sequence 0,1,6,8,0.
  - aluOp=10 in EXECR; regWrite=1 only in ALUWB; retired 0→1.
- lw with wait: op=0000011, memReady low for 3 cycles in MEMREAD.
  - Sequence 0,1,2,3,3,3,3,4,0.
  - adrSrc=1 throughout MEMREAD; regWrite=1 with resultSrc=01 in MEMWB.
- sw wait: op=0100011, memReady low for 2 cycles in MEMWRITE → memWrite=1 for 3 consecutive cycles, then FETCH; regWrite never 1.
- Branch: op=1100011, f3=000.
  - brTaken=1 → pcWrite=1 in BRANCH.
  - Repeat with brTaken=0 → pcWrite=0.
  - aluOp=01 and immSrc=10 in both runs.
- jal and illegal:
  - op=1101111 → sequence 0,1,10,8,0 with pcWrite=1 in JAL.
  - op=1111111 → illegalOp pulse in DECODE, retired +1, back to FETCH.
  - Assert rst while in MEMREAD → FETCH after one edge.
